// File: rtl/am_lock_lane_rx.sv
// Per-lane 40GBASE-R alignment-marker lock: detects this lane's markers and runs the 2-good / N-bad lock FSM.
// Optional saturating bad-marker counter output when AM_LOCK_ERR_CNT_EN is defined.
module am_lock_lane_rx #(
   parameter int BLOCK_W        = 66,
   parameter int LANE_N         = 4,
   parameter int AM_PERIOD      = 16383,
   parameter int AM_CNT_W       = $clog2(AM_PERIOD+1),
   parameter int AM_INVALID_MAX = 4,
   parameter int LANE_ID_W      = $clog2(LANE_N)
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 block_lock_i,
   input  logic                 valid_i,
   input  logic [BLOCK_W-1:0]   data_i,
`ifdef AM_LOCK_ERR_CNT_EN
   output logic [15:0]          am_err_cnt_o,
`endif
   output logic                 valid_o,
   output logic [BLOCK_W-1:0]   data_o,
   output logic                 am_v_o,
   output logic                 lock_v_o,
   output logic                 lock_lost_v_o,
   output logic [LANE_ID_W-1:0] lane_id_o
);

   localparam int INV_W = $clog2(AM_INVALID_MAX+1);
   localparam logic [AM_CNT_W-1:0] LP_PERIOD  = AM_CNT_W'(AM_PERIOD);
   localparam logic [INV_W-1:0]    LP_INV_TOP = INV_W'(AM_INVALID_MAX-1);

   typedef enum logic [1:0] {ST_SEARCH, ST_WAIT2, ST_LOCKED} state_t;

   // Marker bytes packed {M2,M1,M0} so they line up with data_i[25:2].
   function automatic logic [23:0] am_pat(input int lane);
      case (lane)
         0:       am_pat = 24'h477690;
         1:       am_pat = 24'hE6C4F0;
         2:       am_pat = 24'h9B65C5;
         3:       am_pat = 24'h3D79A2;
         default: am_pat = 24'h000000;
      endcase
   endfunction

   state_t                r_state, w_state_nxt;
   logic [AM_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [INV_W-1:0]      r_inv, w_inv_nxt;
   logic [LANE_ID_W-1:0]  r_lane_id, w_lane_id_nxt;
   logic [LANE_ID_W-1:0]  r_lane_out, w_lane_out_nxt;
   logic                  r_valid, r_am_v, r_lost;
   logic [BLOCK_W-1:0]    r_data;
   logic                  w_am_nxt, w_lost_nxt, w_err_inc;
   logic [LANE_N-1:0]     w_hit;
   logic [LANE_ID_W-1:0]  w_hit_id;
   logic                  w_any_hit, w_id_hit, w_slot;

   // BIP bytes 3 and 7 are deliberately excluded from the match.
   for (genvar g = 0; g < LANE_N; g++) begin : g_match
      assign w_hit[g] = valid_i && (data_i[1:0] == 2'b01) &&
                        (data_i[25:2] == am_pat(g)) && (data_i[57:34] == ~am_pat(g));
   end

   always_comb begin
      w_hit_id = '0;
      for (int i = 0; i < LANE_N; i++)
         if (w_hit[i]) w_hit_id = LANE_ID_W'(i);
   end

   assign w_any_hit = |w_hit;
   assign w_id_hit  = w_hit[r_lane_id];
   assign w_slot    = (r_cnt == LP_PERIOD);

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_inv_nxt      = r_inv;
      w_lane_id_nxt  = r_lane_id;
      w_lane_out_nxt = r_lane_out;
      w_am_nxt       = 1'b0;
      w_lost_nxt     = 1'b0;
      w_err_inc      = 1'b0;
      if (!block_lock_i) begin
         w_state_nxt = ST_SEARCH;
         w_cnt_nxt   = '0;
         w_inv_nxt   = '0;
         w_lost_nxt  = (r_state == ST_LOCKED);
      end else if (valid_i) begin
         w_cnt_nxt = w_slot ? '0 : r_cnt + AM_CNT_W'(1);
         case (r_state)
            ST_SEARCH: if (w_any_hit) begin
               w_lane_id_nxt = w_hit_id;
               w_cnt_nxt     = '0;
               w_state_nxt   = ST_WAIT2;
            end
            ST_WAIT2: if (w_slot) begin
               if (w_id_hit) begin
                  w_state_nxt    = ST_LOCKED;
                  w_am_nxt       = 1'b1;
                  w_inv_nxt      = '0;
                  w_lane_out_nxt = r_lane_id;
               end else begin
                  w_state_nxt = ST_SEARCH;
               end
            end
            ST_LOCKED: if (w_slot) begin
               if (w_id_hit) begin
                  w_inv_nxt = '0;
                  w_am_nxt  = 1'b1;
               end else begin
                  w_err_inc = 1'b1;
                  if (r_inv == LP_INV_TOP) begin
                     w_state_nxt = ST_SEARCH;
                     w_lost_nxt  = 1'b1;
                     w_inv_nxt   = '0;
                  end else begin
                     w_inv_nxt = r_inv + INV_W'(1);
                  end
               end
            end
            default: w_state_nxt = ST_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state    <= ST_SEARCH;
         r_cnt      <= '0;
         r_inv      <= '0;
         r_lane_id  <= '0;
         r_lane_out <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_am_v     <= 1'b0;
         r_lost     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_inv      <= w_inv_nxt;
         r_lane_id  <= w_lane_id_nxt;
         r_lane_out <= w_lane_out_nxt;
         r_valid    <= valid_i;
         r_data     <= data_i;
         r_am_v     <= w_am_nxt;
         r_lost     <= w_lost_nxt;
      end
   end

`ifdef AM_LOCK_ERR_CNT_EN
   logic [15:0] r_err_cnt;
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                                r_err_cnt <= '0;
      else if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
   end
   assign am_err_cnt_o = r_err_cnt;
`else
   logic w_unused_err;
   assign w_unused_err = w_err_inc;
`endif

   // State is registered on the same edge as the marker, so lock tracks data_o directly.
   assign lock_v_o      = (r_state == ST_LOCKED);
   assign valid_o       = r_valid;
   assign data_o        = r_data;
   assign am_v_o        = r_am_v;
   assign lock_lost_v_o = r_lost;
   assign lane_id_o     = r_lane_out;

endmodule

// File: tb/tb_am_lock_lane_rx.sv
// Directed vector bench for am_lock_lane_rx with a short marker period (AM_PERIOD=15).
module tb_am_lock_lane_rx;

   localparam int K_AM = 0, K_IDLE = 1, K_BAD = 2;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        block_lock_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [65:0] data_i = '0;
   logic        valid_o, am_v_o, lock_v_o, lock_lost_v_o;
   logic [65:0] data_o;
   logic [1:0]  lane_id_o;
`ifdef AM_LOCK_ERR_CNT_EN
   logic [15:0] am_err_cnt_o;
`endif

   int tests = 0;
   int fails = 0;

   am_lock_lane_rx #(.AM_PERIOD(15)) dut (
      .clk(clk), .nreset(nreset), .block_lock_i(block_lock_i), .valid_i(valid_i), .data_i(data_i),
`ifdef AM_LOCK_ERR_CNT_EN
      .am_err_cnt_o(am_err_cnt_o),
`endif
      .valid_o(valid_o), .data_o(data_o), .am_v_o(am_v_o), .lock_v_o(lock_v_o),
      .lock_lost_v_o(lock_lost_v_o), .lane_id_o(lane_id_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       rep;
      bit       bl;
      int       kind;
      int       lane;
      bit       e_am;
      bit       e_lock;
      bit       e_lost;
      bit [1:0] e_id;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [65:0] blk(input int kind, input int lane);
      logic [7:0] m0, m1, m2;
      case (lane)
         0: begin m0 = 8'h90; m1 = 8'h76; m2 = 8'h47; end
         1: begin m0 = 8'hF0; m1 = 8'hC4; m2 = 8'hE6; end
         2: begin m0 = 8'hC5; m1 = 8'h65; m2 = 8'h9B; end
         default: begin m0 = 8'hA2; m1 = 8'h79; m2 = 8'h3D; end
      endcase
      if (kind == K_IDLE) return {56'h0, 8'h1E, 2'b10};
      blk = {8'h5A, ~m2, ~m1, ~m0, 8'hC3, m2, m1, m0, 2'b01};
      if (kind == K_BAD) blk[10] = ~blk[10];
   endfunction

   function automatic void add(input int rep, input bit bl, input int kind, input int lane,
                               input bit am, input bit lk, input bit lost, input int id);
      vec_t v;
      v.rep = rep; v.bl = bl; v.kind = kind; v.lane = lane;
      v.e_am = am; v.e_lock = lk; v.e_lost = lost; v.e_id = 2'(id);
      vecs.push_back(v);
   endfunction

   task automatic step(input string name, input bit bl, input bit v, input logic [65:0] d,
                       input bit e_am, input bit e_lock, input bit e_lost, input bit [1:0] e_id);
      logic [5:0] act, exp;
      @(negedge clk);
      block_lock_i = bl; valid_i = v; data_i = d;
      @(posedge clk);
      #1;
      act = {valid_o, am_v_o, lock_v_o, lock_lost_v_o, lane_id_o};
      exp = {v, e_am, e_lock, e_lost, e_id};
      tests++;
      if (act !== exp || data_o !== d) begin
         fails++;
         $display("FAIL %s: {valid,am,lock,lost,id}=%b data=%h, expected %b data=%h",
                  name, act, data_o, exp, d);
      end
   endtask

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      // Acquire on lane 2; first marker must not raise am_v_o.
      add(1, 1, K_AM, 2, 0, 0, 0, 0); add(15, 1, K_IDLE, 0, 0, 0, 0, 0); add(1, 1, K_AM, 2, 1, 1, 0, 2);
      // block_lock drop coincident with a good slot marker.
      add(15, 1, K_IDLE, 0, 0, 1, 0, 2); add(1, 0, K_AM, 2, 0, 0, 1, 2); add(1, 0, K_IDLE, 0, 0, 0, 0, 2);
      // False first marker, then a genuine lane1 pair.
      add(1, 1, K_AM, 1, 0, 0, 0, 2); add(15, 1, K_IDLE, 0, 0, 0, 0, 2); add(1, 1, K_BAD, 1, 0, 0, 0, 2);
      add(1, 1, K_AM, 1, 0, 0, 0, 2); add(15, 1, K_IDLE, 0, 0, 0, 0, 2); add(1, 1, K_AM, 1, 1, 1, 0, 1);
      // Wrong-lane slot marker in WAIT_2ND is not reused as a first marker.
      add(1, 0, K_IDLE, 0, 0, 0, 1, 1);
      add(1, 1, K_AM, 1, 0, 0, 0, 1); add(15, 1, K_IDLE, 0, 0, 0, 0, 1); add(1, 1, K_AM, 3, 0, 0, 0, 1);
      add(15, 1, K_IDLE, 0, 0, 0, 0, 1); add(1, 1, K_AM, 3, 0, 0, 0, 1);
      add(15, 1, K_IDLE, 0, 0, 0, 0, 1); add(1, 1, K_AM, 3, 1, 1, 0, 3);
      // Lane0 lock, 3 bad (one is a lane1 marker) + 1 good keeps lock, then 4 bad loses it.
      add(1, 0, K_IDLE, 0, 0, 0, 1, 3);
      add(1, 1, K_AM, 0, 0, 0, 0, 3); add(15, 1, K_IDLE, 0, 0, 0, 0, 3); add(1, 1, K_AM, 0, 1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         add(15, 1, K_IDLE, 0, 0, 1, 0, 0);
         if (k == 1) add(1, 1, K_AM, 1, 0, 1, 0, 0);
         else        add(1, 1, K_BAD, 0, 0, 1, 0, 0);
      end
      add(15, 1, K_IDLE, 0, 0, 1, 0, 0); add(1, 1, K_AM, 0, 1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         add(15, 1, K_IDLE, 0, 0, 1, 0, 0); add(1, 1, K_BAD, 0, 0, 1, 0, 0);
      end
      add(15, 1, K_IDLE, 0, 0, 1, 0, 0); add(1, 1, K_BAD, 0, 0, 0, 1, 0); add(1, 1, K_IDLE, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1 chk("reset_outputs", 80'({valid_o, data_o, am_v_o, lock_v_o, lock_lost_v_o, lane_id_o}), 80'd0);
      @(negedge clk) nreset = 1'b1;

      foreach (vecs[i])
         for (int r = 0; r < vecs[i].rep; r++)
            step($sformatf("vec%0d.%0d", i, r), vecs[i].bl, 1'b1, blk(vecs[i].kind, vecs[i].lane),
                 vecs[i].e_am, vecs[i].e_lock, vecs[i].e_lost, vecs[i].e_id);

      // Gapped valid: invalid cycles carry a marker pattern yet must not count or match.
      step("gap_first", 1, 1, blk(K_AM, 0), 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         step("gap_idle", 1, 1, blk(K_IDLE, 0), 0, 0, 0, 0);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++)
            step("gap_hole", 1, 0, blk(K_AM, 0), 0, 0, 0, 0);
      end
      step("gap_hole_slot", 1, 0, blk(K_AM, 0), 0, 0, 0, 0);
      step("gap_lock", 1, 1, blk(K_AM, 0), 1, 1, 0, 0);

      // Asynchronous reset while locked, sampled between clock edges.
      @(negedge clk);
      #2 nreset = 1'b0;
      #1 chk("async_reset", 80'({valid_o, data_o, am_v_o, lock_v_o, lock_lost_v_o, lane_id_o}), 80'd0);
      @(negedge clk) nreset = 1'b1;
      step("post_reset", 1, 1, blk(K_IDLE, 0), 0, 0, 0, 0);

`ifdef AM_LOCK_ERR_CNT_EN
      step("e_am1", 1, 1, blk(K_AM, 0), 0, 0, 0, 0);
      repeat (15) step("e_idle", 1, 1, blk(K_IDLE, 0), 0, 0, 0, 0);
      step("e_lock", 1, 1, blk(K_AM, 0), 1, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         repeat (15) step("e_idle", 1, 1, blk(K_IDLE, 0), 0, 1, 0, 0);
         step("e_bad", 1, 1, blk(K_BAD, 0), 0, (k != 3), (k == 3), 0);
      end
      chk("err_cnt_4", 80'(am_err_cnt_o), 80'd4);
      step("e_bad_search", 1, 1, blk(K_BAD, 0), 0, 0, 0, 0);
      step("e_am1b", 1, 1, blk(K_AM, 0), 0, 0, 0, 0);
      repeat (15) step("e_idle", 1, 1, blk(K_IDLE, 0), 0, 0, 0, 0);
      step("e_relock", 1, 1, blk(K_AM, 0), 1, 1, 0, 0);
      chk("err_cnt_search", 80'(am_err_cnt_o), 80'd4);
      repeat (15) step("e_idle", 1, 1, blk(K_IDLE, 0), 0, 1, 0, 0);
      step("e_bad5", 1, 1, blk(K_BAD, 0), 0, 1, 0, 0);
      chk("err_cnt_5", 80'(am_err_cnt_o), 80'd5);
      force dut.r_err_cnt = 16'hFFFF;
      #1 release dut.r_err_cnt;
      repeat (15) step("e_idle", 1, 1, blk(K_IDLE, 0), 0, 1, 0, 0);
      step("e_bad_sat", 1, 1, blk(K_BAD, 0), 0, 1, 0, 0);
      chk("err_cnt_sat", 80'(am_err_cnt_o), 80'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/am_lock_lane_rx.md
Name: am_lock_lane_rx

Overview:
- Per-lane alignment marker (AM) lock stage for the 40GBASE-R receive path. Sits directly upstream of the per-lane deskew buffer.
- Input: 66-bit blocks from the block-sync/gearbox stage of one PCS lane. The block detects the lane's alignment markers and acquires/loses AM lock with a 2-good / N-bad rule.
- Emits a marker-valid pulse aligned with the forwarded data, plus lock status. Lock status feeds the cross-lane lock-full AND and the per-lane deskew stage.

Parameters:
- BLOCK_W, 66, block width including 2-bit sync header.
- LANE_N, 4, number of PCS lanes; marker table has LANE_N entries.
- AM_PERIOD, 16383, valid non-marker blocks between consecutive markers.
- AM_CNT_W, $clog2(AM_PERIOD+1), block counter width.
- AM_INVALID_MAX, 4, consecutive bad markers that drop lock.
- LANE_ID_W, $clog2(LANE_N), lane id width.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- block_lock_i  in  1  upstream block lock; low forces SEARCH
- valid_i  in  1  data_i carries a block this cycle
- data_i  in  BLOCK_W  received block; [1:0] sync header, [65:2] payload, byte k at [8k+9:8k+2]
- valid_o  out  1  registered valid_i
- data_o  out  BLOCK_W  registered data_i
- am_v_o  out  1  data_o is an accepted marker for this lane
- lock_v_o  out  1  AM lock held
- lock_lost_v_o  out  1  one-cycle pulse on lock loss
- lane_id_o  out  LANE_ID_W  detected physical lane number, valid while lock_v_o

Behaviour:
- Marker match is combinational on data_i and requires valid_i.
  - data_i[1:0]==2'b01.
  - Bytes 0..2 equal the lane table entry M0..M2.
  - Bytes 4..6 equal ~M0..~M2.
  - Bytes 3 and 7 (BIP) are ignored.
- Lane table:
  - lane0 90/76/47
  - lane1 F0/C4/E6
  - lane2 C5/65/9B
  - lane3 A2/79/3D
- Counter cnt (AM_CNT_W):
  - Cleared on any accepted/expected marker slot.
  - Increments on each valid_i non-slot block.
  - The marker slot is the first valid block after cnt==AM_PERIOD.
  - Invalid cycles (valid_i=0) freeze cnt and the FSM.
- FSM states: SEARCH, WAIT_2ND, LOCKED.
  - SEARCH: a match against any table entry latches lane id, clears cnt and moves to WAIT_2ND.
  - WAIT_2ND, at marker slot:
    - Match with latched id -> LOCKED, am_v_o=1 for that block.
    - Otherwise -> SEARCH. The mismatching block is not re-evaluated as a first marker.
  - LOCKED, at marker slot:
    - Match with latched id -> inv_cnt=0, am_v_o=1.
    - Otherwise inv_cnt+1, with am_v_o=0 and the FSM staying LOCKED.
    - When inv_cnt reaches AM_INVALID_MAX -> SEARCH, lock_lost_v_o pulse.
  - In LOCKED, a match for a different lane id is treated as a mismatch.
- block_lock_i=0 in any state:
  - Next state is SEARCH; cnt and inv_cnt are cleared.
  - lock_lost_v_o pulses if the current state is LOCKED.
  - Takes priority over a simultaneous marker.
- Outputs are registered with 1-cycle latency: data_o, valid_o and am_v_o refer to the same block.
- lock_v_o=1 in LOCKED, including the cycle the lock-accepting marker appears on data_o. It drops in the same cycle lock_lost_v_o pulses.
- lane_id_o holds its last value outside lock.
- Reset values:
  - State SEARCH.
  - valid_o=0, data_o=0, am_v_o=0, lock_v_o=0, lock_lost_v_o=0, lane_id_o=0.
  - cnt=0, inv_cnt=0.
- Reset mid-lock drops all outputs asynchronously, with no lock_lost pulse.
- am_v_o never asserts outside LOCKED (and the WAIT_2ND->LOCKED transition).

Optional Feature:
- Macro: AM_LOCK_ERR_CNT_EN.
- When defined:
  - Adds output am_err_cnt_o [15:0], a saturating count (stops at 16'hFFFF) of bad markers seen in LOCKED.
  - Cleared only by nreset.
  - Increments one cycle after the bad slot block is received.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Lock acquire (AM_PERIOD=15, block_lock_i=1): lane2 marker, 15 idles, lane2 marker -> am_v_o=1 with data_o=second marker; lock_v_o=1; lane_id_o=2; no am_v_o on first marker.
- False first marker: lane1 marker, 15 idles, garbage block at slot -> state back to SEARCH; lock_v_o stays 0; a following lane1 pair then locks.
- Loss of lock: locked on lane0, then 4 consecutive corrupted slot blocks -> lock_lost_v_o one pulse after 4th; lock_v_o=0. Only 3 bad then 1 good -> lock retained, inv_cnt reset.
- Gapped valid: valid_i low for random cycles between markers -> cnt frozen; marker still accepted at the 16th valid block; valid_o mirrors valid_i with 1-cycle delay.
- block_lock_i drop while LOCKED coincident with a good marker -> lock_lost_v_o=1, am_v_o=0, state SEARCH; async nreset mid-lock -> all outputs 0 immediately.
- AM_LOCK_ERR_CNT_EN: 5 bad slots, each followed by re-lock -> am_err_cnt_o counts only bad slots in LOCKED (4 per loss); forced counter at FFFF stays FFFF.
